muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 141 ++++++++++++++
 tb/tb_muldiv_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative 32x32 multiply / divide unit with HI/LO registers.
// Shift-add multiply and restoring divide on magnitudes, 33 cycles per operation.
module muldiv_unit (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2} state_t;

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } md_req_t;

  state_t      state, state_nxt;
  md_req_t     req_r;
  logic [4:0]  cnt;
  logic [31:0] rh, ql, dv;
  logic [31:0] rh_nxt, ql_nxt;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum, div_sh;
  logic [31:0] div_diff;
  logic        div_ge;
  logic [63:0] prod, prod_fix;
  logic [31:0] q_fix, r_fix, fix_hi, fix_lo;
  logic        sgn, neg_pq, neg_r;
  logic        done_r;
  logic [31:0] hi_r, lo_r;

  // op[0]==0 selects the signed variants (MULT, DIV)
  assign a_mag = (~op[0] & a[31]) ? -a : a;
  assign b_mag = (~op[0] & b[31]) ? -b : b;

  // One iteration: rh holds the partial product high word / partial remainder,
  // ql the multiplier being consumed / quotient being built.
  always_comb begin
    mul_sum  = {1'b0, rh} + (ql[0] ? {1'b0, dv} : 33'd0);
    div_sh   = {rh, ql[31]};
    div_ge   = div_sh >= {1'b0, dv};
    div_diff = div_sh[31:0] - dv;
    if (req_r.op[1]) begin
      rh_nxt = div_ge ? div_diff : div_sh[31:0];
      ql_nxt = {ql[30:0], div_ge};
    end else begin
      rh_nxt = mul_sum[32:1];
      ql_nxt = {mul_sum[0], ql[31:1]};
    end
  end

  always_comb begin
    sgn      = ~req_r.op[0];
    neg_pq   = sgn & (req_r.a[31] ^ req_r.b[31]);
    neg_r    = sgn & req_r.a[31];
    prod     = {rh, ql};
    prod_fix = neg_pq ? -prod : prod;
    q_fix    = neg_pq ? -ql : ql;
    r_fix    = neg_r ? -rh : rh;
    fix_hi   = prod_fix[63:32];
    fix_lo   = prod_fix[31:0];
    if (req_r.op[1]) begin
      if (req_r.b == 32'd0) begin
        fix_hi = req_r.a;
        fix_lo = 32'hFFFF_FFFF;
      end else begin
        fix_hi = r_fix;
        fix_lo = q_fix;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (cnt == 5'd31) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      req_r  <= '0;
      cnt    <= '0;
      rh     <= '0;
      ql     <= '0;
      dv     <= '0;
      done_r <= 1'b0;
      hi_r   <= '0;
      lo_r   <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            req_r <= '{op: op, a: a, b: b};
            cnt   <= '0;
            rh    <= '0;
            ql    <= op[1] ? a_mag : b_mag;
            dv    <= op[1] ? b_mag : a_mag;
          end else begin
            if (mthi) hi_r <= wdata;
            if (mtlo) lo_r <= wdata;
          end
        end
        CALC: begin
          rh  <= rh_nxt;
          ql  <= ql_nxt;
          cnt <= cnt + 5'd1;
        end
        FIX: begin
          hi_r   <= fix_hi;
          lo_r   <= fix_lo;
          done_r <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = done_r;
  assign hi   = hi_r;
  assign lo   = lo_r;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus randomized
// operations against a plain-arithmetic reference model.
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        rstn, start, mthi, mtlo;
  logic [1:0]  op;
  logic [31:0] a, b, wdata;
  logic        busy, done;
  logic [31:0] hi, lo;

  int errors = 0;
  int checks = 0;

  muldiv_unit dut (
    .clk(clk), .rstn(rstn), .start(start), .op(op), .a(a), .b(b),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // {hi, lo} expected for an operation
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] p;
    logic [31:0] uq, ur;
    sx = $signed(x);
    sy = $signed(y);
    case (o)
      2'b00: begin q = sx * sy; p = q; end
      2'b01: p = {32'd0, x} * {32'd0, y};
      2'b10: begin
        if (y == 32'd0) p = {x, 32'hFFFF_FFFF};
        else begin
          q = sx / sy;
          r = sx % sy;
          p = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (y == 32'd0) p = {x, 32'hFFFF_FFFF};
        else begin
          uq = x / y;
          ur = x % y;
          p = {ur, uq};
        end
      end
    endcase
    return p;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 300));
      default: return $urandom;
    endcase
  endfunction

  // mode 0: quiet; 1: random start/move noise while busy; 2: start+mthi re-asserted before E5
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input int mode, input string name);
    logic [63:0] exp;
    logic [31:0] hi0, lo0;
    int lat, busy_bad, hold_bad;
    bit seen;
    exp = model(o, x, y);
    hi0 = hi; lo0 = lo;
    lat = 0; busy_bad = 0; hold_bad = 0; seen = 0;
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL %s busy_after_start: got %b want 1", name, busy); end
    for (int c = 1; c <= 40 && !seen; c++) begin
      if (mode == 1) begin
        start = 1'($urandom); mthi = 1'($urandom); mtlo = 1'($urandom);
        wdata = $urandom; op = 2'($urandom); a = $urandom; b = $urandom;
      end
      if (mode == 2 && c == 5) begin
        start = 1'b1; op = 2'b01; a = 32'd2; b = 32'd2; mthi = 1'b1; wdata = 32'h55;
      end
      if (mode == 2 && c == 6) begin start = 1'b0; mthi = 1'b0; end
      @(posedge clk); #1;
      if (done === 1'b1) begin
        seen = 1; lat = c;
      end else begin
        if (busy !== 1'b1) busy_bad++;
        if (hi !== hi0 || lo !== lo0) hold_bad++;
      end
    end
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    checks++;
    if (lat != 33) begin errors++; $display("FAIL %s latency: got %0d want 33", name, lat); end
    checks++;
    if (busy_bad != 0) begin errors++; $display("FAIL %s busy_during_op: %0d low cycles want 0", name, busy_bad); end
    checks++;
    if (hold_bad != 0) begin errors++; $display("FAIL %s hilo_hold: %0d changed cycles want 0", name, hold_bad); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL %s busy_at_done: got %b want 0", name, busy); end
    checks++;
    if (hi !== exp[63:32]) begin errors++; $display("FAIL %s hi: got %h want %h", name, hi, exp[63:32]); end
    checks++;
    if (lo !== exp[31:0]) begin errors++; $display("FAIL %s lo: got %h want %h", name, lo, exp[31:0]); end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL %s done_pulse_width: got %b want 0", name, done); end
  endtask

  task automatic test_reset();
    checks++;
    if ({busy, done} !== 2'b00) begin errors++; $display("FAIL reset busy_done: got %b want 00", {busy, done}); end
    checks++;
    if ({hi, lo} !== 64'd0) begin errors++; $display("FAIL reset hilo: got %h want 0", {hi, lo}); end
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    // start accepted on the very first edge after release
    run_op(2'b01, 32'd7, 32'd6, 0, "first_after_reset");
  endtask

  task automatic test_vectors();
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "multu_max");
    checks++;
    if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001) begin errors++; $display("FAIL multu_max_const: got %h want fffffffe00000001", {hi, lo}); end
    run_op(2'b00, 32'hFFFF_FFFD, 32'd5, 0, "mult_neg");
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0, "div_neg");
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_ovf");
    checks++;
    if ({hi, lo} !== 64'h0000_0000_8000_0000) begin errors++; $display("FAIL div_ovf_const: got %h want 0000000080000000", {hi, lo}); end
    run_op(2'b11, 32'd100, 32'd0, 0, "divu_by0");
    run_op(2'b10, 32'hFFFF_FF9C, 32'd0, 0, "div_by0");
    run_op(2'b10, 32'd7, 32'hFFFF_FFFE, 0, "div_pos_neg");
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 0, "mult_minmin");
  endtask

  task automatic test_moves();
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'hA5A5_0001;
    @(posedge clk); #1;
    mthi = 1'b0; mtlo = 1'b0;
    checks++;
    if ({hi, lo} !== {2{32'hA5A5_0001}}) begin errors++; $display("FAIL move_both: got %h want %h", {hi, lo}, {2{32'hA5A5_0001}}); end
    mthi = 1'b1; wdata = 32'h1111;
    @(posedge clk); #1;
    mthi = 1'b0;
    checks++;
    if ({hi, lo} !== {32'h1111, 32'hA5A5_0001}) begin errors++; $display("FAIL move_hi: got %h want %h", {hi, lo}, {32'h1111, 32'hA5A5_0001}); end
    mtlo = 1'b1; wdata = 32'h2222;
    @(posedge clk); #1;
    mtlo = 1'b0;
    checks++;
    if ({hi, lo} !== {32'h1111, 32'h2222}) begin errors++; $display("FAIL move_lo: got %h want %h", {hi, lo}, {32'h1111, 32'h2222}); end
    // start beats simultaneous moves
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'hDEAD_BEEF;
    run_op(2'b11, 32'd50, 32'd7, 0, "start_wins");
  endtask

  task automatic test_ignore_start();
    run_op(2'b11, 32'd10, 32'd3, 2, "ignore_start");
    checks++;
    if (hi === 32'h55) begin errors++; $display("FAIL ignore_start_mthi: got %h want not 00000055", hi); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++)
      run_op(2'($urandom), pick(), pick(), 1, "random");
  endtask

  task automatic test_reset_mid();
    int spurious;
    spurious = 0;
    start = 1'b1; op = 2'b01; a = 32'h1234_5678; b = 32'h9ABC_DEF0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({busy, done} !== 2'b00) begin errors++; $display("FAIL reset_mid busy_done: got %b want 00", {busy, done}); end
    checks++;
    if ({hi, lo} !== 64'd0) begin errors++; $display("FAIL reset_mid hilo: got %h want 0", {hi, lo}); end
    @(negedge clk);
    rstn = 1'b1; mtlo = 1'b1; wdata = 32'h1234;
    @(posedge clk); #1;
    mtlo = 1'b0;
    checks++;
    if ({hi, lo} !== {32'd0, 32'h1234}) begin errors++; $display("FAIL reset_mid mtlo: got %h want %h", {hi, lo}, {32'd0, 32'h1234}); end
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0 || lo !== 32'h1234) spurious++;
    end
    checks++;
    if (spurious != 0) begin errors++; $display("FAIL reset_mid discard: %0d active cycles want 0", spurious); end
    run_op(2'b00, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 0, "after_reset_mid");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    op = 2'b00; a = '0; b = '0; wdata = '0;
    #1;
    test_reset();
    test_vectors();
    test_moves();
    test_ignore_start();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
